// File: rtl/sccb_cam_arbiter.sv
// sccb_cam_arbiter: round-robin share of one SCCB write engine between N_REQ requesters,
// with operand latching, post-transaction gap and a done watchdog.
`default_nettype none

module sccb_cam_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int IW            = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_dev,
  input  logic [8*N_REQ-1:0] req_reg,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   req_gnt,
  output logic [N_REQ-1:0]   req_done,
  output logic [N_REQ-1:0]   req_err,
  output logic               sccb_start,
  output logic [23:0]        sccb_indata,
  input  logic               sccb_done,
  output logic               busy,
  output logic [IW-1:0]      grant_idx,
  output logic               timeout_flag
);

  // One counter serves both the BUSY watchdog and the GAP timer.
  localparam int CMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [IW-1:0]     win;
  logic              found;
  logic [N_REQ-1:0]  gnt_n, done_n, err_n;
  logic              start_n, tflag_n;
  logic [23:0]       indata_n;
  logic [IW-1:0]     idx_n;

  // Round-robin search starting just above the last owner.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % N_REQ]) begin
        win   = IW'((int'(ptr) + k) % N_REQ);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    ptr_n    = ptr;
    idx_n    = grant_idx;
    indata_n = sccb_indata;
    tflag_n  = timeout_flag;
    gnt_n    = '0;
    done_n   = '0;
    err_n    = '0;
    start_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) begin
          gnt_n[win] = 1'b1;
          start_n    = 1'b1;
          indata_n   = {req_dev[8*win +: 8], req_reg[8*win +: 8], req_data[8*win +: 8]};
          idx_n      = win;
          ptr_n      = win;
          cnt_n      = '0;
          state_n    = S_BUSY;
        end
      end
      S_BUSY: begin
        // A done arriving on the terminal count still counts as success.
        if (sccb_done) begin
          done_n[grant_idx] = 1'b1;
          cnt_n             = '0;
          state_n           = S_GAP;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          done_n[grant_idx] = 1'b1;
          err_n[grant_idx]  = 1'b1;
          tflag_n           = 1'b1;
          cnt_n             = '0;
          state_n           = S_GAP;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == CW'(GAP_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      ptr          <= IW'(N_REQ - 1);
      grant_idx    <= '0;
      sccb_indata  <= '0;
      timeout_flag <= 1'b0;
      req_gnt      <= '0;
      req_done     <= '0;
      req_err      <= '0;
      sccb_start   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      ptr          <= ptr_n;
      grant_idx    <= idx_n;
      sccb_indata  <= indata_n;
      timeout_flag <= tflag_n;
      req_gnt      <= gnt_n;
      req_done     <= done_n;
      req_err      <= err_n;
      sccb_start   <= start_n;
    end
  end

  assign busy = (state != S_IDLE);

endmodule

`default_nettype wire
